// File: rtl/rfsoc_config.sv
// ============================================================================
// Module   : rfsoc_config (package)
// Brief    : Shared configuration-link types and constants for the RFSoC fabric.
// Revision : 1.0 - serial mask link state type and defaults added
// ============================================================================
`default_nettype none

package rfsoc_config;

    // Select indices of the shared serial configuration lines.
    localparam int          CFG_SEL_W        = 2;
    localparam logic [1:0]  CFG_SEL_SDATA    = 2'd0;
    localparam logic [1:0]  CFG_SEL_MASK_CLK = 2'd1;

    localparam int MASK_W_DEF       = 16;
    localparam int MASK_TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        LINK_IDLE   = 2'd0,
        LINK_SHIFT  = 2'd1,
        LINK_COMMIT = 2'd2
    } link_state_t;

endpackage : rfsoc_config

`default_nettype wire

// File: rtl/sync_edge_det.sv
// ============================================================================
// Module   : sync_edge_det
// Brief    : N-stage synchronizer with a one-cycle rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_sync,
    output logic o_rise
);

    logic [STAGES-1:0] r_chain;
    logic [STAGES-1:0] r_fill;
    logic              r_prev;

    // r_prev holds 1 until the chain has been reloaded after reset, so a line
    // already high at release cannot masquerade as a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
            r_fill  <= '0;
            r_prev  <= 1'b1;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
            r_fill  <= {r_fill[STAGES-2:0], 1'b1};
            if (r_fill[STAGES-1]) begin
                r_prev <= r_chain[STAGES-1];
            end
        end
    end

    assign o_sync = r_chain[STAGES-1];
    assign o_rise = r_chain[STAGES-1] & ~r_prev;

endmodule : sync_edge_det

`default_nettype wire

// File: rtl/mask_cfg_rx.sv
// ============================================================================
// Module   : mask_cfg_rx
// Brief    : Serial-link receiver that deserializes and atomically commits the
//            waveform begin/end mask register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mask_cfg_rx
    import rfsoc_config::*;
#(
    parameter int MASK_W      = MASK_W_DEF,
    parameter int TIMEOUT     = MASK_TIMEOUT_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_sdata,
    input  logic              i_mask_clk,
    output logic [MASK_W-1:0] o_mask_out,
    output logic              o_mask_valid,
    output logic              o_frame_err,
    output logic              o_busy
);

    localparam int BCNT_W = $clog2(MASK_W);
    localparam int TCNT_W = $clog2(TIMEOUT);

    logic [SYNC_STAGES-1:0] r_sdata_sync;
    logic                   w_sdata_s;
    logic                   w_rise;
    logic                   w_clk_s;

    link_state_t            r_state;
    logic [MASK_W-1:0]      r_shreg;
    logic [BCNT_W-1:0]      r_bcnt;
    logic [TCNT_W-1:0]      r_tcnt;
    logic [MASK_W-1:0]      r_mask;
    logic                   r_valid;
    logic                   r_err;
    logic                   r_busy;

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_clk_sync (
        .clk    (clk),
        .rst    (rst),
        .i_d    (i_mask_clk),
        .o_sync (w_clk_s),
        .o_rise (w_rise)
    );

    // Same depth as the mask_clk chain so data stays aligned with its edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sdata_sync <= '0;
        end else begin
            r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], i_sdata};
        end
    end

    assign w_sdata_s = r_sdata_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LINK_IDLE;
            r_shreg <= '0;
            r_bcnt  <= '0;
            r_tcnt  <= '0;
            r_mask  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                LINK_IDLE: begin
                    r_tcnt <= '0;
                    if (w_rise) begin
                        r_shreg <= {r_shreg[MASK_W-2:0], w_sdata_s};
                        r_bcnt  <= BCNT_W'(1);
                        r_busy  <= 1'b1;
                        r_state <= LINK_SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                LINK_SHIFT: begin
                    r_busy <= 1'b1;
                    if (w_rise) begin
                        r_shreg <= {r_shreg[MASK_W-2:0], w_sdata_s};
                        r_bcnt  <= r_bcnt + BCNT_W'(1);
                        r_tcnt  <= '0;
                        if (r_bcnt == BCNT_W'(MASK_W-1)) begin
                            r_state <= LINK_COMMIT;
                        end
                    end else if (r_tcnt == TCNT_W'(TIMEOUT-1)) begin
                        r_err   <= 1'b1;
                        r_shreg <= '0;
                        r_bcnt  <= '0;
                        r_tcnt  <= '0;
                        r_busy  <= 1'b0;
                        r_state <= LINK_IDLE;
                    end else begin
                        r_tcnt  <= r_tcnt + TCNT_W'(1);
                    end
                end
                LINK_COMMIT: begin
                    // A rise here violates link timing and is dropped silently.
                    r_mask  <= r_shreg;
                    r_valid <= 1'b1;
                    r_shreg <= '0;
                    r_bcnt  <= '0;
                    r_busy  <= 1'b1;
                    r_state <= LINK_IDLE;
                end
                default: begin
                    r_state <= LINK_IDLE;
                end
            endcase
        end
    end

    assign o_mask_out   = r_mask;
    assign o_mask_valid = r_valid;
    assign o_frame_err  = r_err;
    assign o_busy       = r_busy;

    logic w_unused;
    assign w_unused = w_clk_s;

endmodule : mask_cfg_rx

`default_nettype wire
